// File: rtl/booth_pkg.sv
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types, recode selects and width helpers for the
//                radix-4 Booth sequential multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_sel_t;

    // Extended operand width: two guard bits so unsigned operands stay positive.
    function automatic int booth_w(input int data_size);
        return data_size + 2;
    endfunction

    function automatic int booth_acc_w(input int data_size);
        return data_size + 4;
    endfunction

    function automatic int booth_steps(input int data_size);
        return data_size / 2 + 1;
    endfunction

    function automatic int booth_cnt_w(input int data_size);
        return $clog2(booth_steps(data_size) + 1);
    endfunction

    function automatic booth_sel_t booth_decode(input logic [2:0] triplet);
        case (triplet)
            3'b001, 3'b010: return PM;
            3'b011:         return P2M;
            3'b100:         return N2M;
            3'b101, 3'b110: return NM;
            default:        return ZERO;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_radix4_recoder.sv
// ============================================================================
//  Module      : booth_radix4_recoder
//  Description : Maps a Booth triplet {q[1],q[0],q_1} and the extended
//                multiplicand to the signed addend for one radix-4 step.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_radix4_recoder
    import booth_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic [2:0]                        triplet_i,
    input  logic [booth_w(DATA_SIZE)-1:0]     m_i,
    output logic [booth_acc_w(DATA_SIZE)-1:0] addend_o
);

    localparam int W     = booth_w(DATA_SIZE);
    localparam int ACC_W = booth_acc_w(DATA_SIZE);

    logic [ACC_W-1:0] w_m_x;
    logic [ACC_W-1:0] w_m2_x;

    assign w_m_x  = {{2{m_i[W-1]}}, m_i};
    assign w_m2_x = {m_i[W-1], m_i, 1'b0};

    always_comb begin
        addend_o = '0;
        case (booth_decode(triplet_i))
            PM:      addend_o = w_m_x;
            P2M:     addend_o = w_m2_x;
            NM:      addend_o = -w_m_x;
            N2M:     addend_o = -w_m2_x;
            default: addend_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_radix4_multiplier.sv
// ============================================================================
//  Module      : booth_radix4_multiplier
//  Description : Sequential radix-4 Booth multiplier, signed or unsigned,
//                with start/ready request, valid/ack result and abort.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic                     signed_mode_i,
    input  logic [DATA_SIZE-1:0]     multiplicand_i,
    input  logic [DATA_SIZE-1:0]     multiplier_i,
    input  logic                     abort_i,
    input  logic                     result_ack_i,
    output logic                     ready_o,
    output logic                     data_valid_o,
    output logic [2*DATA_SIZE-1:0]   product_o
);

    localparam int W     = booth_w(DATA_SIZE);
    localparam int ACC_W = booth_acc_w(DATA_SIZE);
    localparam int N     = booth_steps(DATA_SIZE);
    localparam int CNT_W = booth_cnt_w(DATA_SIZE);
    localparam int SH_W  = ACC_W + W + 1;

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [ACC_W-1:0]       acc_q,     acc_d;
    logic [W-1:0]           q_q,       q_d;
    logic                   q1_q,      q1_d;
    logic [DATA_SIZE-1:0]   m_q,       m_d;
    logic                   mode_q,    mode_d;
    logic [2*DATA_SIZE-1:0] product_q, product_d;
    logic                   valid_q,   valid_d;

    logic [W-1:0]           w_m_ext;
    logic [W-1:0]           w_q_ext;
    logic [ACC_W-1:0]       w_addend;
    logic [ACC_W-1:0]       w_sum;
    logic signed [SH_W-1:0] w_cat;
    logic signed [SH_W-1:0] w_shift;

    // Multiplicand is kept narrow and re-extended each step using the latched mode.
    assign w_m_ext = mode_q        ? {{2{m_q[DATA_SIZE-1]}}, m_q}
                                   : {2'b00, m_q};
    assign w_q_ext = signed_mode_i ? {{2{multiplier_i[DATA_SIZE-1]}}, multiplier_i}
                                   : {2'b00, multiplier_i};

    booth_radix4_recoder #(
        .DATA_SIZE (DATA_SIZE)
    ) u_recoder (
        .triplet_i ({q_q[1:0], q1_q}),
        .m_i       (w_m_ext),
        .addend_o  (w_addend)
    );

    assign w_sum   = acc_q + w_addend;
    assign w_cat   = {w_sum, q_q, q1_q};
    assign w_shift = w_cat >>> 2;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        mode_d    = mode_q;
        product_d = product_q;
        valid_d   = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(N);
                    acc_d   = '0;
                    q_d     = w_q_ext;
                    q1_d    = 1'b0;
                    m_d     = multiplicand_i;
                    mode_d  = signed_mode_i;
                end
            end
            ST_CALC: begin
                acc_d = w_shift[SH_W-1:W+1];
                q_d   = w_shift[W:1];
                q1_d  = w_shift[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    product_d = w_shift[2*DATA_SIZE:1];
                    valid_d   = 1'b1;
                end
            end
            ST_DONE: begin
                if (result_ack_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Abort overrides everything, including a final-step product load.
        if (abort_i) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            product_d = product_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign data_valid_o = valid_q;
    assign product_o    = product_q;

endmodule

`default_nettype wire
